// File: rtl/mem_block_arbiter_pkg.sv
// Shared types and constants for the block memory arbiter.
// The state encoding and port indices are used by the arbiter, its
// interface and its picker.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    localparam logic P_DCACHE = 1'b0;
    localparam logic P_ICACHE = 1'b1;

endpackage

// File: rtl/mem_block_arbiter_if.sv
// Bundle of both cache request ports and the backing-memory port.
// The slave modport is the arbiter's view; the master modport is the view of
// the environment, which holds the caches and the memory.
// Handshake: a cache raises reqN and holds reqN, weN, addrN and wdataN until
// it sees doneN. It drops reqN no later than the cycle after doneN. While the
// arbiter is BUSY it holds mem_en high and the mem_* inputs stable until the
// memory pulses mem_block_valid for one cycle. state_dbg exposes the FSM state.
interface mem_block_arbiter_if #(
    parameter int DATA_WIDTH         = 32,
    parameter int ADDR_WIDTH         = 10,
    parameter int BLOCK_OFFSET_WIDTH = 3
);
    import mem_arb_pkg::*;

    localparam int BLK_W = DATA_WIDTH << BLOCK_OFFSET_WIDTH;

    logic                  req0;
    logic                  req1;
    logic                  we0;
    logic                  we1;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [BLK_W-1:0]      wdata0;
    logic [BLK_W-1:0]      wdata1;
    logic                  done0;
    logic                  done1;
    logic [BLK_W-1:0]      rdata;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_we;
    logic                  mem_en;
    logic [BLK_W-1:0]      mem_block_din;
    logic                  mem_block_valid;
    logic [BLK_W-1:0]      mem_block_dout;
    logic                  busy;
    arb_state_t            state_dbg;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  mem_block_valid, mem_block_dout,
        output done0, done1, rdata, mem_addr, mem_we, mem_en, mem_block_din,
        output busy, state_dbg
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output mem_block_valid, mem_block_dout,
        input  done0, done1, rdata, mem_addr, mem_we, mem_en, mem_block_din,
        input  busy, state_dbg
    );

endinterface

// File: rtl/mem_block_arbiter_pick.sv
// Combinational winner selection between the two cache ports.
// MEM_ARB_ROUND_ROBIN_EN defined: on a tie the port that was not granted last
// wins. Undefined: port 0 (data cache) always wins a tie, and last is unused.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic valid,
    output logic gnt
);

    assign valid = req0 | req1;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // On a tie, favour the port that was not granted last time.
    always_comb begin
        gnt = P_DCACHE;
        if (req0 && req1) gnt = ~last;
        else if (req1)    gnt = P_ICACHE;
    end
`else
    logic unused_last;
    assign unused_last = last;

    // The data cache wins whenever it is requesting.
    always_comb begin
        gnt = req0 ? P_DCACHE : P_ICACHE;
    end
`endif

endmodule

// File: rtl/mem_block_arbiter.sv
// Shares one block-wide backing memory port between the data cache (port 0)
// and the instruction cache (port 1). In IDLE it grants one requester and
// latches its request, then drives the memory from those latches in BUSY.
// In DONE it pulses done for the granted port for one cycle.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin tie breaking; the default build
// uses fixed priority.
module mem_block_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH         = 32,
    parameter int ADDR_WIDTH         = 10,
    parameter int BLOCK_OFFSET_WIDTH = 3
) (
    input  logic              clk,
    input  logic              rst,
    mem_block_arbiter_if.slave bus
);

    localparam int BLK_W = DATA_WIDTH << BLOCK_OFFSET_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] BLK_MASK = {ADDR_WIDTH{1'b1}} << BLOCK_OFFSET_WIDTH;

    arb_state_t            state_q, state_d;
    logic                  gnt_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [BLK_W-1:0]      din_q;
    logic [BLK_W-1:0]      rdata_q;
    logic                  pick_valid;
    logic                  pick_gnt;
    logic                  last_w;
    logic                  grant;

    assign grant = (state_q == IDLE) && pick_valid;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_q;

    // Remember which port was granted most recently, for tie breaking.
    always_ff @(posedge clk) begin
        if (rst)        last_q <= P_ICACHE;
        else if (grant) last_q <= pick_gnt;
    end
    assign last_w = last_q;
`else
    assign last_w = P_ICACHE;
`endif

    mem_arb_pick u_pick (
        .req0  (bus.req0),
        .req1  (bus.req1),
        .last  (last_w),
        .valid (pick_valid),
        .gnt   (pick_gnt)
    );

    // State register plus request latches. The memory inputs come only from
    // these latches, so they stay stable for the whole of BUSY.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= P_DCACHE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                gnt_q  <= pick_gnt;
                we_q   <= pick_gnt ? bus.we1 : bus.we0;
                addr_q <= (pick_gnt ? bus.addr1 : bus.addr0) & BLK_MASK;
                din_q  <= pick_gnt ? bus.wdata1 : bus.wdata0;
            end
            if ((state_q == BUSY) && bus.mem_block_valid && !we_q)
                rdata_q <= bus.mem_block_dout;
        end
    end

    // Next state and per-state control outputs.
    always_comb begin
        state_d   = state_q;
        bus.mem_en = 1'b0;
        bus.mem_we = 1'b0;
        bus.done0  = 1'b0;
        bus.done1  = 1'b0;
        unique case (state_q)
            IDLE: if (pick_valid) state_d = BUSY;
            BUSY: begin
                bus.mem_en = 1'b1;
                bus.mem_we = we_q;
                if (bus.mem_block_valid) state_d = DONE;
            end
            DONE: begin
                bus.done0 = (gnt_q == P_DCACHE);
                bus.done1 = (gnt_q == P_ICACHE);
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.mem_addr      = addr_q;
    assign bus.mem_block_din = din_q;
    assign bus.rdata         = rdata_q;
    assign bus.busy          = (state_q != IDLE);
    assign bus.state_dbg     = state_q;

endmodule

// File: tb/tb_mem_block_arbiter.sv
// Bench for mem_block_arbiter. The reference model tracks which ports are
// pending, the last grant and the refill data the caches should see. Expected
// winners follow the tie-break rule directly, and expected rdata is queued
// when the memory answers.
`timescale 1ns/1ps
module tb_mem_block_arbiter;
    import mem_arb_pkg::*;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int OW = 3;
    localparam int BW = DW << OW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    mem_block_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_OFFSET_WIDTH(OW)) bus ();

    mem_block_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_OFFSET_WIDTH(OW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // reference model state
    logic [AW-1:0] t_addr  [2];
    logic          t_we    [2];
    logic [BW-1:0] t_wdata [2];
    bit            pend    [2];
    bit            m_last;
    logic [BW-1:0] m_rdata;
    logic [BW-1:0] exp_q[$];

    function automatic logic [BW-1:0] rand_blk();
        logic [BW-1:0] b;
        for (int i = 0; i < (1 << OW); i++) b[i*DW +: DW] = $urandom;
        return b;
    endfunction

    function automatic int model_pick();
        if (pend[0] && pend[1]) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            return (m_last == 1'b1) ? 0 : 1;
`else
            return 0;
`endif
        end
        return pend[1] ? 1 : 0;
    endfunction

    // driver tasks
    task automatic raise(input int p, input logic we, input logic [AW-1:0] a, input logic [BW-1:0] d);
        t_we[p] = we; t_addr[p] = a; t_wdata[p] = d; pend[p] = 1'b1;
        if (p == 0) begin
            bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
        end else begin
            bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
        end
    endtask

    task automatic drop(input int p);
        pend[p] = 1'b0;
        if (p == 0) bus.req0 = 1'b0;
        else        bus.req1 = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drop(0); drop(1);
        bus.mem_block_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        m_last = 1'b1;
        m_rdata = '0;
    endtask

    // One complete transaction for the model's expected winner: grant, BUSY
    // hold for lat cycles, memory strobe, DONE pulse, then back to IDLE.
    // Called at a negedge where the DUT is IDLE and requests are already set.
    task automatic service(input int lat);
        int p;
        int waited;
        logic [AW-1:0] ea;
        logic [BW-1:0] dout;
        logic [BW-1:0] exp_rd;
        logic [BW-1:0] got_exp;
        p = model_pick();
        m_last = p[0];
        ea = t_addr[p];
        ea[OW-1:0] = '0;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!bus.mem_en && waited < 20);
        checks++;
        if (waited != 1 || bus.mem_en !== 1'b1) begin
            errors++;
            $display("FAIL grant_latency: port %0d mem_en=%b after %0d cycles, required 1 after 1 cycle", p, bus.mem_en, waited);
        end
        checks++;
        if (bus.mem_addr !== ea || bus.mem_we !== t_we[p] || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL grant_latch: port %0d addr=%h we=%b busy=%b, required addr=%h we=%b busy=1", p, bus.mem_addr, bus.mem_we, bus.busy, ea, t_we[p]);
        end
        if (t_we[p]) begin
            checks++;
            if (bus.mem_block_din !== t_wdata[p]) begin
                errors++;
                $display("FAIL grant_wdata: port %0d din=%h required %h", p, bus.mem_block_din, t_wdata[p]);
            end
        end
        // wdata is sampled at grant only; disturb it for the rest of BUSY
        if (p == 0) bus.wdata0 = ~t_wdata[0];
        else        bus.wdata1 = ~t_wdata[1];
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            checks++;
            if (bus.mem_en !== 1'b1 || bus.done0 !== 1'b0 || bus.done1 !== 1'b0 || bus.mem_addr !== ea ||
                bus.mem_we !== t_we[p] || (t_we[p] && bus.mem_block_din !== t_wdata[p])) begin
                errors++;
                $display("FAIL busy_hold: port %0d cycle %0d en=%b done=%b%b addr=%h we=%b, required en=1 done=00 addr=%h we=%b din stable",
                         p, i, bus.mem_en, bus.done1, bus.done0, bus.mem_addr, bus.mem_we, ea, t_we[p]);
            end
        end
        dout = rand_blk();
        bus.mem_block_valid = 1'b1;
        bus.mem_block_dout  = dout;
        exp_rd = t_we[p] ? m_rdata : dout;
        exp_q.push_back(exp_rd);
        @(negedge clk);
        bus.mem_block_valid = 1'b0;
        bus.mem_block_dout  = rand_blk();
        got_exp = exp_q.pop_front();
        checks++;
        if (bus.done0 !== (p == 0) || bus.done1 !== (p == 1) || bus.mem_en !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: done1,done0=%b%b mem_en=%b, required done for port %0d only and mem_en=0", bus.done1, bus.done0, bus.mem_en, p);
        end
        checks++;
        if (bus.rdata !== got_exp) begin
            errors++;
            $display("FAIL done_rdata: port %0d we=%b rdata=%h required %h", p, t_we[p], bus.rdata, got_exp);
        end
        m_rdata = exp_rd;
        drop(p);
        @(negedge clk);
        checks++;
        if (bus.done0 !== 1'b0 || bus.done1 !== 1'b0 || bus.mem_en !== 1'b0 || bus.busy !== 1'b0 || bus.rdata !== m_rdata) begin
            errors++;
            $display("FAIL back_to_idle: done=%b%b en=%b busy=%b rdata=%h, required 00 0 0 rdata=%h", bus.done1, bus.done0, bus.mem_en, bus.busy, bus.rdata, m_rdata);
        end
    endtask

    // scenarios
    task automatic test_reset();
        @(negedge clk); @(negedge clk);
        checks++;
        if (bus.state_dbg !== IDLE || bus.busy !== 1'b0 || bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: state=%0d busy=%b en=%b we=%b, required IDLE 0 0 0", bus.state_dbg, bus.busy, bus.mem_en, bus.mem_we);
        end
        checks++;
        if (bus.done0 !== 1'b0 || bus.done1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_done: done1,done0=%b%b, required 00", bus.done1, bus.done0);
        end
        checks++;
        if (bus.mem_addr !== '0 || bus.mem_block_din !== '0 || bus.rdata !== '0) begin
            errors++;
            $display("FAIL reset_data: addr=%h din=%h rdata=%h, required all zero", bus.mem_addr, bus.mem_block_din, bus.rdata);
        end
        rst = 1'b0;
        m_last = 1'b1;
        m_rdata = '0;
    endtask

    task automatic test_single_refill();
        raise(1, 1'b0, 10'h3A5, rand_blk());
        service(8);
    endtask

    task automatic test_writeback();
        logic [BW-1:0] pat;
        for (int i = 0; i < (1 << OW); i++) pat[i*DW +: DW] = 32'h1111_1111 * (i + 1);
        raise(0, 1'b1, 10'h12F, pat);
        service(4);
    endtask

    task automatic test_valid_idle();
        bus.mem_block_valid = 1'b1;
        bus.mem_block_dout  = rand_blk();
        @(negedge clk);
        bus.mem_block_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (bus.busy !== 1'b0 || bus.done0 !== 1'b0 || bus.done1 !== 1'b0 || bus.rdata !== m_rdata) begin
                errors++;
                $display("FAIL valid_idle: busy=%b done=%b%b rdata=%h, required 0 00 rdata=%h", bus.busy, bus.done1, bus.done0, bus.rdata, m_rdata);
            end
        end
    endtask

    task automatic test_simultaneous();
        int p;
        do_reset();
        raise(0, $urandom_range(0, 1), AW'($urandom), rand_blk());
        raise(1, $urandom_range(0, 1), AW'($urandom), rand_blk());
        for (int r = 0; r < 4; r++) begin
            p = model_pick();
            service($urandom_range(0, 5));
            if (r < 3) raise(p, $urandom_range(0, 1), AW'($urandom), rand_blk());
        end
        for (int k = 0; k < 2; k++)
            if (pend[0] || pend[1]) service($urandom_range(0, 3));
    endtask

    task automatic test_back_to_back();
        raise(1, 1'b0, AW'($urandom), rand_blk());
        service(2);
        raise(1, 1'b1, AW'($urandom), rand_blk());
        service(0);
        // requester has dropped req: no duplicate grant may follow
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.mem_en !== 1'b0 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL no_regrant: mem_en=%b busy=%b, required 0 0", bus.mem_en, bus.busy);
            end
        end
    endtask

    task automatic test_reset_mid_busy();
        raise(0, 1'b0, AW'($urandom), rand_blk());
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.mem_en !== 1'b0 || bus.busy !== 1'b0 || bus.done0 !== 1'b0 || bus.done1 !== 1'b0 || bus.rdata !== '0) begin
            errors++;
            $display("FAIL reset_abort: en=%b busy=%b done=%b%b rdata=%h, required 0 0 00 0", bus.mem_en, bus.busy, bus.done1, bus.done0, bus.rdata);
        end
        drop(0);
        rst = 1'b0;
        m_last = 1'b1;
        m_rdata = '0;
        bus.mem_block_valid = 1'b1;
        bus.mem_block_dout  = rand_blk();
        @(negedge clk);
        bus.mem_block_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (bus.mem_en !== 1'b0 || bus.busy !== 1'b0 || bus.done0 !== 1'b0 || bus.done1 !== 1'b0 || bus.rdata !== '0) begin
                errors++;
                $display("FAIL late_strobe: en=%b busy=%b done=%b%b rdata=%h, required 0 0 00 0", bus.mem_en, bus.busy, bus.done1, bus.done0, bus.rdata);
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 30; it++) begin
            for (int p = 0; p < 2; p++)
                if (!pend[p] && $urandom_range(0, 1) == 1)
                    raise(p, $urandom_range(0, 1), AW'($urandom), rand_blk());
            if (!pend[0] && !pend[1])
                raise($urandom_range(0, 1), $urandom_range(0, 1), AW'($urandom), rand_blk());
            service($urandom_range(0, 6));
        end
    endtask

    initial begin
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.we0 = 1'b0; bus.we1 = 1'b0;
        bus.addr0 = '0; bus.addr1 = '0;
        bus.wdata0 = '0; bus.wdata1 = '0;
        bus.mem_block_valid = 1'b0;
        bus.mem_block_dout = '0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        m_last = 1'b1;
        m_rdata = '0;

        test_reset();
        test_single_refill();
        test_writeback();
        test_valid_idle();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid_busy();
        test_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
